memory_sync_be: RTL

//  Clocked, parametrised successor to the asynchronous start-strobe data memory.

---
 rtl/memory_sync_be.sv | 113 +++++++++++
 1 files changed

// File: rtl/memory_sync_be.sv
// memory_sync_be: single-port byte-enabled word memory with start/ready/valid handshake and READ_LATENCY-cycle reads
// Ports:
//   i_clock                rising-edge clock
//   i_reset                synchronous active-high reset
//   i_start                request strobe, accepted when i_start && o_ready
//   i_write_enabled        1 = write, 0 = read
//   i_byte_enable          per-byte write mask, bit i -> data[8i+7:8i]
//   i_address              byte address
//   i_input_data           write data
//   o_ready                can accept a request this cycle
//   o_valid                one-cycle pulse, o_output_data holds read result
//   o_output_data          last successful read data, held between reads
//   o_write_done           one-cycle pulse, write committed
//   o_err_invalid_address  one-cycle pulse, word index out of range
//   o_err_misaligned       one-cycle pulse, address not word aligned
module memory_sync_be #(
    parameter int WORD_SIZE    = 32,
    parameter int MEMORY_SIZE  = 1024,
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic                   i_write_enabled,
    input  logic [WORD_SIZE/8-1:0] i_byte_enable,
    input  logic [ADDR_WIDTH-1:0]  i_address,
    input  logic [WORD_SIZE-1:0]   i_input_data,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [WORD_SIZE-1:0]   o_output_data,
    output logic                   o_write_done,
    output logic                   o_err_invalid_address,
    output logic                   o_err_misaligned
);
    localparam int BYTES = WORD_SIZE / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int IDX_W = (MEMORY_SIZE > 1) ? $clog2(MEMORY_SIZE) : 1;

    typedef enum logic {IDLE, READ_WAIT} state_t;

    state_t                 r_state, w_next_state;
    logic [2:0]             r_count, w_next_count;
    logic [IDX_W-1:0]       r_index;
    logic [WORD_SIZE-1:0]   r_mem [MEMORY_SIZE];

    logic                   w_accept, w_misaligned, w_invalid, w_ok;
    logic                   w_do_write, w_do_read, w_fire;
    logic [ADDR_WIDTH-1:0]  w_word;
    logic [IDX_W-1:0]       w_index, w_read_index;

    assign o_ready      = (r_state == IDLE) && !i_reset;
    assign w_accept     = i_start && o_ready;
    assign w_word       = i_address >> SHIFT;
    assign w_misaligned = |(i_address & ADDR_WIDTH'(BYTES - 1));
    assign w_invalid    = w_word >= ADDR_WIDTH'(MEMORY_SIZE);
    assign w_ok         = w_accept && !w_misaligned && !w_invalid;
    assign w_do_write   = w_ok && i_write_enabled;
    assign w_do_read    = w_ok && !i_write_enabled;
    assign w_index      = w_word[IDX_W-1:0];
    // Single-cycle reads use the live request; multi-cycle reads use the index latched at acceptance.
    assign w_read_index = (r_state == IDLE) ? w_index : r_index;
    assign w_fire       = (r_state == IDLE) ? (w_do_read && READ_LATENCY == 1)
                                            : (r_count == 3'(READ_LATENCY - 1));

    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        if (r_state == IDLE) begin
            if (w_do_read && READ_LATENCY > 1) begin
                w_next_state = READ_WAIT;
                w_next_count = 3'd1;
            end
        end else if (r_count == 3'(READ_LATENCY - 1)) begin
            w_next_state = IDLE;
            w_next_count = 3'd0;
        end else begin
            w_next_count = r_count + 3'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state               <= IDLE;
            r_count               <= 3'd0;
            r_index               <= '0;
            o_valid               <= 1'b0;
            o_output_data         <= '0;
            o_write_done          <= 1'b0;
            o_err_invalid_address <= 1'b0;
            o_err_misaligned      <= 1'b0;
        end else begin
            r_state               <= w_next_state;
            r_count               <= w_next_count;
            o_valid               <= w_fire;
            o_write_done          <= w_do_write;
            o_err_invalid_address <= w_accept && w_invalid;
            o_err_misaligned      <= w_accept && w_misaligned;
            if (w_do_read)
                r_index <= w_index;
            if (w_fire)
                o_output_data <= r_mem[w_read_index];
        end
    end

    // RAM array kept free of reset so it maps onto block memory; contents survive reset.
    always_ff @(posedge i_clock) begin
        if (w_do_write)
            for (int b = 0; b < BYTES; b++)
                if (i_byte_enable[b])
                    r_mem[w_index][8*b +: 8] <= i_input_data[8*b +: 8];
    end
endmodule
